// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared constants and types for the sequential binary-to-BCD
//               converter (state encoding, digit width, add-3 correction).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

   localparam int c_BCD_W = 4;
   localparam logic [c_BCD_W-1:0] c_ADD3_THRESH = 4'd5;
   localparam logic [c_BCD_W-1:0] c_ADD3_VALUE  = 4'd3;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Digits 5..9 become 8..12 so the following left shift carries correctly.
   function automatic logic [c_BCD_W-1:0] add3_correct(input logic [c_BCD_W-1:0] d);
      return (d >= c_ADD3_THRESH) ? (d + c_ADD3_VALUE) : d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_cell.sv
// ============================================================================
// Module      : bcd_digit_cell
// Description : One BCD digit slice of the double-dabble chain: add-3
//               correction followed by a one-bit left shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_clear,
   input  logic               i_en,
   input  logic               i_shift_in,
   output logic [c_BCD_W-1:0] o_digit_next,
   output logic               o_carry
);

   logic [c_BCD_W-1:0] r_digit;
   logic [c_BCD_W-1:0] w_corr;

   assign w_corr       = add3_correct(r_digit);
   assign o_digit_next = {w_corr[c_BCD_W-2:0], i_shift_in};
   assign o_carry      = w_corr[c_BCD_W-1];

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_digit <= '0;
      end else if (i_en) begin
         r_digit <= o_digit_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module      : bin2bcd_seq
// Description : Multi-cycle binary-to-BCD converter, one input bit per clock,
//               with overflow detection and leading-zero blanking mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 40,
   parameter int DIGITS = 7
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [BIN_W-1:0]          bin_in,
   output logic                      busy,
   output logic                      done,
   output logic [c_BCD_W*DIGITS-1:0] bcd_out,
   output logic                      overflow,
   output logic [DIGITS-1:0]         digit_en
);

   localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIN_W - 1);

   state_t r_state;
   state_t w_state_next;
   logic   w_load;
   logic   w_shift_en;
   logic   w_last;

   logic [BIN_W-1:0]          r_shift;
   logic [c_CNT_W-1:0]        r_cnt;
   logic                      r_ovf_acc;
   logic                      r_done;
   logic [c_BCD_W*DIGITS-1:0] r_bcd;
   logic                      r_ovf;
   logic [DIGITS-1:0]         r_en;

   logic [c_BCD_W*DIGITS-1:0] w_next_bcd;
   logic [DIGITS-1:0]         w_carry;
   logic [DIGITS-1:0]         w_chain_in;
   logic [DIGITS-1:0]         w_mask;
   logic                      w_any;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_shift_en   = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_shift_en = 1'b1;
            if (r_cnt == '0) begin
               w_last       = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_digit
         if (g == 0) begin : g_ones
            assign w_chain_in[g] = r_shift[BIN_W-1];
         end else begin : g_upper
            assign w_chain_in[g] = w_carry[g-1];
         end

         bcd_digit_cell u_cell (
            .clk          (clk),
            .reset        (reset),
            .i_clear      (w_load),
            .i_en         (w_shift_en),
            .i_shift_in   (w_chain_in[g]),
            .o_digit_next (w_next_bcd[g*c_BCD_W +: c_BCD_W]),
            .o_carry      (w_carry[g])
         );
      end
   endgenerate

   // A digit stays lit if it or any more significant digit is nonzero.
   always_comb begin
      w_mask = '0;
      w_any  = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         w_any     = w_any | (|w_next_bcd[k*c_BCD_W +: c_BCD_W]);
         w_mask[k] = w_any;
      end
      w_mask[0] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift   <= '0;
         r_cnt     <= '0;
         r_ovf_acc <= 1'b0;
         r_done    <= 1'b0;
         r_bcd     <= '0;
         r_ovf     <= 1'b0;
         r_en      <= DIGITS'(1);
      end else begin
         r_done <= w_last;
         if (w_load) begin
            r_shift   <= bin_in;
            r_cnt     <= c_CNT_LAST;
            r_ovf_acc <= 1'b0;
         end else if (w_shift_en) begin
            r_shift   <= {r_shift[BIN_W-2:0], 1'b0};
            r_cnt     <= r_cnt - 1'b1;
            r_ovf_acc <= r_ovf_acc | w_carry[DIGITS-1];
         end
         if (w_last) begin
            r_bcd <= w_next_bcd;
            r_ovf <= r_ovf_acc | w_carry[DIGITS-1];
            r_en  <= w_mask;
         end
      end
   end

   assign busy     = (r_state == ST_SHIFT);
   assign done     = r_done;
   assign bcd_out  = r_bcd;
   assign overflow = r_ovf;
   assign digit_en = r_en;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq (40/7, 8/3 and 8/2 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bin2bcd_seq;

   localparam int W = 40;
   localparam int D = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset;
   logic           start;
   logic [W-1:0]   bin_in;
   logic           busy;
   logic           done;
   logic [4*D-1:0] bcd_out;
   logic           overflow;
   logic [D-1:0]   digit_en;

   logic        start8;
   logic [7:0]  bin8;
   logic        busy_a, done_a, ovf_a;
   logic [11:0] bcd_a;
   logic [2:0]  en_a;
   logic        busy_b, done_b, ovf_b;
   logic [7:0]  bcd_b;
   logic [1:0]  en_b;

   int checks   = 0;
   int failures = 0;

   bin2bcd_seq #(.BIN_W(W), .DIGITS(D)) dut (
      .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out),
      .overflow(overflow), .digit_en(digit_en)
   );

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
      .clk(clk), .reset(reset), .start(start8), .bin_in(bin8),
      .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
      .overflow(ovf_a), .digit_en(en_a)
   );

   bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
      .clk(clk), .reset(reset), .start(start8), .bin_in(bin8),
      .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
      .overflow(ovf_b), .digit_en(en_b)
   );

   // Decimal reference computed with plain arithmetic.
   function automatic void model(input longint unsigned v, input int nd,
                                 output logic [63:0] bcd, output logic ovf,
                                 output logic [15:0] en);
      longint unsigned pw;
      longint unsigned r;
      pw = 1;
      for (int i = 0; i < nd; i++) pw = pw * 10;
      ovf = (v >= pw);
      r   = v % pw;
      bcd = '0;
      en  = '0;
      for (int i = 0; i < nd; i++) begin
         bcd[4*i +: 4] = 4'(r % 10);
         en[i]         = (r != 0) || (i == 0);
         r             = r / 10;
      end
   endfunction

   logic           e_busy, e_done, e_ovf;
   logic [4*D-1:0] e_bcd;
   logic [D-1:0]   e_en;
   int             m_left;
   bit             chk_en;

   initial begin
      logic [63:0] pb;
      logic        po;
      logic [15:0] pe;
      pb = '0; po = 1'b0; pe = '0;
      m_left = 0; chk_en = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_bcd = '0; e_ovf = 1'b0; e_en = D'(1);
      forever begin
         @(posedge clk);
         e_done = 1'b0;
         if (reset) begin
            m_left = 0;
            chk_en = 1'b1;
            e_bcd  = '0;
            e_ovf  = 1'b0;
            e_en   = D'(1);
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               e_done = 1'b1;
               e_bcd  = pb[4*D-1:0];
               e_ovf  = po;
               e_en   = pe[D-1:0];
            end
         end else if (start) begin
            model(64'(bin_in), D, pb, po, pe);
            m_left = W;
         end
         e_busy = (m_left > 0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            checks++;
            if (busy !== e_busy || done !== e_done || bcd_out !== e_bcd ||
                overflow !== e_ovf || digit_en !== e_en) begin
               failures++;
               $display("FAIL cycle_model t=%0t got busy=%b done=%b bcd=%h ovf=%b en=%b want busy=%b done=%b bcd=%h ovf=%b en=%b",
                        $time, busy, done, bcd_out, overflow, digit_en,
                        e_busy, e_done, e_bcd, e_ovf, e_en);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic pulse_start(input logic [W-1:0] v);
      @(negedge clk);
      bin_in = v;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bin_in = W'({$urandom, $urandom});
   endtask

   task automatic wait_done(output int lat, output int busy_n, output bit ok);
      lat    = 0;
      ok     = 1'b0;
      busy_n = int'(busy);
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         busy_n += int'(busy);
         if (done) begin
            lat = i;
            ok  = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL done_timeout got=no_done expected=done within 200 cycles");
      end
   endtask

   task automatic convert(input string name, input logic [W-1:0] v,
                          input logic [63:0] exp_bcd, input logic exp_ovf,
                          input logic [D-1:0] exp_en);
      int lat, bn;
      bit ok;
      pulse_start(v);
      wait_done(lat, bn, ok);
      if (ok) begin
         chk({name, "_bcd"}, 64'(bcd_out), exp_bcd);
         chk({name, "_ovf"}, 64'(overflow), 64'(exp_ovf));
         chk({name, "_en"},  64'(digit_en), 64'(exp_en));
         chk({name, "_lat"}, 64'(lat), 64'(W));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, bn, ndone;
      bit ok;
      reset = 1'b1; start = 1'b0; bin_in = '0; start8 = 1'b0; bin8 = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_bcd",  64'(bcd_out),  64'h0);
      chk("rst_en",   64'(digit_en), 64'h1);
      chk("rst_busy", 64'(busy),     64'h0);
      chk("rst_done", 64'(done),     64'h0);
      chk("rst_ovf",  64'(overflow), 64'h0);

      convert("zero", 40'd0, 64'h0, 1'b0, 7'b0000001);

      pulse_start(40'd1234567);
      wait_done(lat, bn, ok);
      if (ok) begin
         chk("c1234567_bcd",  64'(bcd_out),  64'h1234567);
         chk("c1234567_en",   64'(digit_en), 64'h7f);
         chk("c1234567_ovf",  64'(overflow), 64'h0);
         chk("c1234567_busy", 64'(bn),       64'd40);
      end

      convert("c9999999", 40'd9999999,       64'h9999999, 1'b0, 7'b1111111);
      convert("c1e7",     40'd10000000,      64'h0,       1'b1, 7'b0000001);
      convert("cmax",     40'hFF_FFFF_FFFF,  64'h1627775, 1'b1, 7'b1111111);
      convert("c305",     40'd305,           64'h305,     1'b0, 7'b0000111);

      // start during a conversion must be ignored
      pulse_start(40'd77);
      repeat (10) @(negedge clk);
      start = 1'b1; bin_in = 40'd42;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bn, ok);
      if (ok) chk("ignore_bcd", 64'(bcd_out), 64'h77);

      // start held high: back-to-back conversions
      @(negedge clk);
      bin_in = 40'd111; start = 1'b1;
      wait_done(lat, bn, ok);
      if (ok) chk("b2b0_bcd", 64'(bcd_out), 64'h111);
      bin_in = 40'd222;
      wait_done(lat, bn, ok);
      if (ok) begin
         chk("b2b1_bcd", 64'(bcd_out), 64'h222);
         chk("b2b1_gap", 64'(lat), 64'd41);
      end
      bin_in = 40'd333;
      wait_done(lat, bn, ok);
      if (ok) begin
         chk("b2b2_bcd", 64'(bcd_out), 64'h333);
         chk("b2b2_gap", 64'(lat), 64'd41);
      end
      start = 1'b0;

      // reset pulsed mid-conversion
      pulse_start(40'd55555);
      repeat (18) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_bcd",  64'(bcd_out),  64'h0);
      chk("midrst_en",   64'(digit_en), 64'h1);
      chk("midrst_busy", 64'(busy),     64'h0);
      ndone = 0;
      repeat (45) begin
         @(negedge clk);
         ndone += int'(done);
      end
      chk("midrst_nodone", 64'(ndone), 64'h0);
      convert("after_rst", 40'd4096, 64'h4096, 1'b0, 7'b0001111);

      // narrow builds: 8/3 and 8/2
      @(negedge clk);
      bin8 = 8'd255; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; bin8 = 8'd0;
      ok = 1'b0; lat = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (done_a) begin lat = i; ok = 1'b1; break; end
      end
      chk("n255_seen", 64'(ok), 64'h1);
      if (ok) begin
         chk("n255_lat",   64'(lat),    64'd8);
         chk("n255_bcd",   64'(bcd_a),  64'h255);
         chk("n255_ovf",   64'(ovf_a),  64'h0);
         chk("n255_en",    64'(en_a),   64'h7);
         chk("n255_busy",  64'(busy_a), 64'h0);
         chk("n255b_done", 64'(done_b), 64'h1);
         chk("n255b_bcd",  64'(bcd_b),  64'h55);
         chk("n255b_ovf",  64'(ovf_b),  64'h1);
      end

      @(negedge clk);
      bin8 = 8'd100; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      ok = 1'b0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (done_b) begin ok = 1'b1; break; end
      end
      chk("n100_seen", 64'(ok), 64'h1);
      if (ok) begin
         chk("n100b_bcd",  64'(bcd_b),  64'h0);
         chk("n100b_ovf",  64'(ovf_b),  64'h1);
         chk("n100b_en",   64'(en_b),   64'h1);
         chk("n100b_busy", 64'(busy_b), 64'h0);
         chk("n100a_bcd",  64'(bcd_a),  64'h100);
         chk("n100a_ovf",  64'(ovf_a),  64'h0);
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
